// File: rtl/hwpf_stride_req_arb.sv
// Round-robin arbiter sharing the HPDcache prefetch request port between stride engines,
// with per-engine inflight/wait throttling. Define HWPF_STRIDE_ARB_OUT_REG_EN for a registered request path.
module hwpf_stride_req_arb #(
  parameter  int unsigned NUM_HW_PREFETCH = 4,
  parameter  int unsigned CLINE_W         = 58,
  parameter  int unsigned CNT_W           = 16,
  localparam int unsigned TID_W           = $clog2(NUM_HW_PREFETCH)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_HW_PREFETCH-1:0]         eng_req_valid_i,
  output logic [NUM_HW_PREFETCH-1:0]         eng_req_ready_o,
  input  logic [NUM_HW_PREFETCH*CLINE_W-1:0] eng_req_cline_i,
  input  logic [NUM_HW_PREFETCH*CNT_W-1:0]   eng_ninflight_i,
  input  logic [NUM_HW_PREFETCH*CNT_W-1:0]   eng_nwait_i,
  output logic [NUM_HW_PREFETCH-1:0]         eng_rsp_valid_o,
  output logic [NUM_HW_PREFETCH-1:0]         eng_busy_o,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [CLINE_W-1:0]                 mem_req_cline_o,
  output logic [TID_W-1:0]                   mem_req_tid_o,
  input  logic                               mem_rsp_valid_i,
  input  logic [TID_W-1:0]                   mem_rsp_tid_i
);

  localparam int unsigned N = NUM_HW_PREFETCH;
  typedef logic [TID_W-1:0] tid_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [N-1:0][CLINE_W-1:0] cline_arr;
  logic [N-1:0][CNT_W-1:0]   ninf_arr, nwait_arr;
  cnt_t [N-1:0]              inflight_q, inflight_d;
  cnt_t [N-1:0]              wait_q, wait_d;
  tid_t                      ptr_q, ptr_d;
  logic [N-1:0]              eligible;
  logic                      grant_vld;
  tid_t                      grant_tid, scan_idx;
  logic                      acc_vld;
  tid_t                      acc_tid;
  logic [N-1:0]              accept;
  logic [N-1:0]              rsp_hit;
  logic                      rsp_underflow;

  assign cline_arr = eng_req_cline_i;
  assign ninf_arr  = eng_ninflight_i;
  assign nwait_arr = eng_nwait_i;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible[i] = eng_req_valid_i[i] && (wait_q[i] == '0) &&
                    ((ninf_arr[i] == '0) || (inflight_q[i] < ninf_arr[i]));
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_tid = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = tid_t'((32'(ptr_q) + k) % N);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_tid = scan_idx;
      end
    end
  end

`ifdef HWPF_STRIDE_ARB_OUT_REG_EN
  logic                 out_vld_q;
  tid_t                 out_tid_q;
  logic [CLINE_W-1:0]   out_cline_q;
  logic                 load;

  // The register may be refilled in the same cycle it drains.
  assign load    = rst_ni && grant_vld && (!out_vld_q || mem_req_ready_i);
  assign acc_vld = load;
  assign acc_tid = grant_tid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q   <= 1'b0;
      out_tid_q   <= '0;
      out_cline_q <= '0;
    end else if (load) begin
      out_vld_q   <= 1'b1;
      out_tid_q   <= grant_tid;
      out_cline_q <= cline_arr[grant_tid];
    end else if (mem_req_ready_i) begin
      out_vld_q   <= 1'b0;
    end
  end

  assign mem_req_valid_o = out_vld_q;
  assign mem_req_tid_o   = out_tid_q;
  assign mem_req_cline_o = out_cline_q;
`else
  logic lock_q;
  tid_t lock_tid_q;
  tid_t sel_tid;

  // While locked the held grant bypasses eligibility so tid/cline stay stable until the handshake.
  assign sel_tid         = lock_q ? lock_tid_q : grant_tid;
  assign mem_req_valid_o = rst_ni && (lock_q || grant_vld);
  assign mem_req_tid_o   = mem_req_valid_o ? sel_tid : '0;
  assign mem_req_cline_o = mem_req_valid_o ? cline_arr[sel_tid] : '0;
  assign acc_vld         = mem_req_valid_o && mem_req_ready_i;
  assign acc_tid         = sel_tid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_tid_q <= '0;
    end else if (mem_req_valid_o && !mem_req_ready_i) begin
      lock_q     <= 1'b1;
      lock_tid_q <= sel_tid;
    end else begin
      lock_q     <= 1'b0;
    end
  end
`endif

  always_comb begin
    accept          = '0;
    rsp_hit         = '0;
    eng_rsp_valid_o = '0;
    rsp_underflow   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      accept[i]          = acc_vld && (acc_tid == tid_t'(i));
      eng_rsp_valid_o[i] = rst_ni && mem_rsp_valid_i && (mem_rsp_tid_i == tid_t'(i));
      rsp_hit[i]         = eng_rsp_valid_o[i] && (inflight_q[i] != '0);
      if (eng_rsp_valid_o[i] && (inflight_q[i] == '0)) rsp_underflow = 1'b1;
    end
  end

  assign eng_req_ready_o = accept;

  always_comb begin
    inflight_d = inflight_q;
    wait_d     = wait_q;
    ptr_d      = ptr_q;
    eng_busy_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (accept[i] && rsp_hit[i]) begin
        inflight_d[i] = inflight_q[i];
      end else if (accept[i] && (inflight_q[i] != '1)) begin
        inflight_d[i] = inflight_q[i] + cnt_t'(1);
      end else if (rsp_hit[i]) begin
        inflight_d[i] = inflight_q[i] - cnt_t'(1);
      end
      if (accept[i]) begin
        wait_d[i] = nwait_arr[i];
      end else if (wait_q[i] != '0) begin
        wait_d[i] = wait_q[i] - cnt_t'(1);
      end
      eng_busy_o[i] = (inflight_q[i] != '0) || (wait_q[i] != '0);
    end
    if (acc_vld) begin
      ptr_d = (acc_tid == tid_t'(N - 1)) ? '0 : acc_tid + tid_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      wait_q     <= '0;
      ptr_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      wait_q     <= wait_d;
      ptr_q      <= ptr_d;
    end
  end

  // A response for an engine with nothing outstanding is dropped; flag it.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!rsp_underflow)
        else $warning("hwpf_stride_req_arb: stray response tid %0d ignored", mem_rsp_tid_i);
    end
  end

endmodule

// File: tb/tb_hwpf_stride_req_arb.sv
// Directed self-checking bench for hwpf_stride_req_arb (default build, combinational request path).
module tb_hwpf_stride_req_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned CW  = 58;
  localparam int unsigned CNT = 16;
  localparam int unsigned TW  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][CW-1:0]   cline;
  logic [N-1:0][CNT-1:0]  ninf;
  logic [N-1:0][CNT-1:0]  nwait;
  logic [N-1:0]           rsp_valid_o;
  logic [N-1:0]           busy;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [CW-1:0]          mem_cline;
  logic [TW-1:0]          mem_tid;
  logic                   rsp_valid;
  logic [TW-1:0]          rsp_tid;

  int ncomp = 0;
  int nfail = 0;

  hwpf_stride_req_arb #(
    .NUM_HW_PREFETCH (N),
    .CLINE_W         (CW),
    .CNT_W           (CNT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .eng_req_valid_i (req_valid),
    .eng_req_ready_o (req_ready),
    .eng_req_cline_i (cline),
    .eng_ninflight_i (ninf),
    .eng_nwait_i     (nwait),
    .eng_rsp_valid_o (rsp_valid_o),
    .eng_busy_o      (busy),
    .mem_req_valid_o (mem_valid),
    .mem_req_ready_i (mem_ready),
    .mem_req_cline_o (mem_cline),
    .mem_req_tid_o   (mem_tid),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_tid_i   (rsp_tid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp)
      else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    ninf      = '0;
    nwait     = '0;
    mem_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_tid   = '0;
    step();
    step();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(N); i++) cline[i] = 58'h100 + 58'(i);

    // Reset state
    do_reset();
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_tid",   64'(mem_tid),   64'd0);
    chk("rst_cline", 64'(mem_cline), 64'd0);

    // 1: all engines, unthrottled -> 0,1,2,3,0
    req_valid = 4'hF;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("t1_valid", 64'(mem_valid), 64'd1);
      chk("t1_tid",   64'(mem_tid),   64'(k % 4));
      chk("t1_ready", 64'(req_ready), 64'(1 << (k % 4)));
      chk("t1_cline", 64'(mem_cline), 64'h100 + 64'(k % 4));
      step();
    end
    req_valid = '0;

    // 2: engine 1 with ninflight=2
    do_reset();
    ninf[1]   = 16'd2;
    req_valid = 4'b0010;
    settle();
    chk("t2_iss0", 64'(mem_valid), 64'd1);
    chk("t2_tid0", 64'(mem_tid),   64'd1);
    step();
    chk("t2_iss1", 64'(mem_valid), 64'd1);
    step();
    chk("t2_blk0", 64'(mem_valid), 64'd0);
    chk("t2_busy", 64'(busy[1]),   64'd1);
    step();
    chk("t2_blk1", 64'(mem_valid), 64'd0);
    rsp_valid = 1'b1;
    rsp_tid   = 2'd1;
    settle();
    chk("t2_rsp",  64'(rsp_valid_o), 64'b0010);
    chk("t2_blk2", 64'(mem_valid),   64'd0);
    step();
    rsp_valid = 1'b0;
    settle();
    chk("t2_iss2", 64'(mem_valid), 64'd1);
    chk("t2_tid2", 64'(mem_tid),   64'd1);
    step();
    chk("t2_blk3", 64'(mem_valid), 64'd0);

    // 3: engine 2 with nwait=3 -> issues at t, t+4, t+8
    do_reset();
    nwait[2]  = 16'd3;
    req_valid = 4'b0100;
    settle();
    for (int k = 0; k < 9; k++) begin
      chk("t3_valid", 64'(mem_valid), 64'((k % 4) == 0));
      if (k == 1) chk("t3_busy", 64'(busy), 64'b0100);
      step();
    end
    req_valid = '0;

    // 4: lock holds grant of engine 0 while ready is low
    do_reset();
    req_valid = 4'b0100;
    settle();
    chk("t4_pre_tid", 64'(mem_tid), 64'd2);
    step();
    req_valid = 4'b0001;
    mem_ready = 1'b0;
    settle();
    chk("t4_lock_v",   64'(mem_valid), 64'd1);
    chk("t4_lock_tid", 64'(mem_tid),   64'd0);
    step();
    req_valid = 4'b1001;
    settle();
    for (int k = 1; k < 5; k++) begin
      chk("t4_hold_tid",   64'(mem_tid),   64'd0);
      chk("t4_hold_cline", 64'(mem_cline), 64'h100);
      chk("t4_hold_rdy",   64'(req_ready), 64'd0);
      step();
    end
    mem_ready = 1'b1;
    settle();
    chk("t4_hs_tid", 64'(mem_tid),   64'd0);
    chk("t4_hs_rdy", 64'(req_ready), 64'b0001);
    step();
    chk("t4_next_tid", 64'(mem_tid),   64'd3);
    chk("t4_next_rdy", 64'(req_ready), 64'b1000);

    // 5: accept + response same engine; stray response
    do_reset();
    req_valid = 4'b0001;
    settle();
    chk("t5_acc0", 64'(req_ready), 64'b0001);
    step();
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    settle();
    chk("t5_acc1", 64'(req_ready),   64'b0001);
    chk("t5_rsp0", 64'(rsp_valid_o), 64'b0001);
    step();
    req_valid = '0;
    rsp_tid   = 2'd2;
    settle();
    chk("t5_infl0",  64'(dut.inflight_q[0]),  64'd1);
    chk("t5_stray",  64'(dut.rsp_underflow),  64'd1);
    chk("t5_rsp2",   64'(rsp_valid_o),        64'b0100);
    step();
    rsp_valid = 1'b0;
    settle();
    chk("t5_infl2",  64'(dut.inflight_q[2]), 64'd0);
    chk("t5_infl0b", 64'(dut.inflight_q[0]), 64'd1);
    chk("t5_busy",   64'(busy),              64'b0001);

    // 6: reset mid-stream with three requests outstanding
    do_reset();
    req_valid = 4'b0111;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("t6_tid", 64'(mem_tid), 64'(k));
      step();
    end
    chk("t6_busy_pre", 64'(busy), 64'b0111);
    rst_n     = 1'b0;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    settle();
    chk("t6_r_valid", 64'(mem_valid),          64'd0);
    chk("t6_r_ready", 64'(req_ready),          64'd0);
    chk("t6_r_rsp",   64'(rsp_valid_o),        64'd0);
    chk("t6_r_busy",  64'(busy),               64'd0);
    chk("t6_r_tid",   64'(mem_tid),            64'd0);
    chk("t6_r_cline", 64'(mem_cline),          64'd0);
    chk("t6_r_inf0",  64'(dut.inflight_q[0]),  64'd0);
    chk("t6_r_inf1",  64'(dut.inflight_q[1]),  64'd0);
    chk("t6_r_inf2",  64'(dut.inflight_q[2]),  64'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    rsp_tid   = 2'd1;
    settle();
    chk("t6_restart", 64'(mem_tid),          64'd0);
    chk("t6_stray",   64'(dut.rsp_underflow), 64'd1);
    chk("t6_rsp1",    64'(rsp_valid_o),      64'b0010);
    step();
    rsp_valid = 1'b0;
    settle();
    chk("t6_inf1",  64'(dut.inflight_q[1]), 64'd0);
    chk("t6_next",  64'(mem_tid),           64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
